// File: rtl/reorder_buffer_pkg.sv
// Shared definitions for the reorder buffer: entry type codes, default widths, FSM states.
package reorder_buffer_pkg;

  localparam int unsigned DefDepthBit = 4;
  localparam int unsigned DefTypeBit  = 2;

  // Entry type codes carried in issue_type.
  localparam int unsigned TypeReg = 0;
  localparam int unsigned TypeSt  = 1;
  localparam int unsigned TypeBr  = 2;
  localparam int unsigned TypeNop = 3;

  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StStWait = 2'd1,
    StFlush  = 2'd2
  } rob_state_e;

endpackage

// File: rtl/reorder_buffer_if.sv
// Bundle of all ROB-facing signals: issue, query, writeback, commit, store release and flush.
interface reorder_buffer_if
  import reorder_buffer_pkg::*;
#(
  parameter int unsigned DEPTH_BIT = DefDepthBit,
  parameter int unsigned TYPE_BIT  = DefTypeBit
) ();

  logic                 full;
  logic                 empty;
  logic [DEPTH_BIT-1:0] free_id;

  logic                 issue_valid;
  logic [TYPE_BIT-1:0]  issue_type;
  logic [4:0]           issue_rd;
  logic [31:0]          issue_value;
  logic                 issue_ready;
  logic                 issue_pred;
  logic [31:0]          issue_alt_pc;

  logic [DEPTH_BIT-1:0] qry1_id;
  logic [DEPTH_BIT-1:0] qry2_id;
  logic                 qry1_ready;
  logic                 qry2_ready;
  logic [31:0]          qry1_value;
  logic [31:0]          qry2_value;

  logic                 wb0_valid;
  logic [DEPTH_BIT-1:0] wb0_id;
  logic [31:0]          wb0_value;
  logic                 wb1_valid;
  logic [DEPTH_BIT-1:0] wb1_id;
  logic [31:0]          wb1_value;

  logic                 dep_valid;
  logic [4:0]           dep_rd;
  logic [DEPTH_BIT-1:0] dep_id;

  logic                 commit_valid;
  logic [4:0]           commit_rd;
  logic [DEPTH_BIT-1:0] commit_id;
  logic [31:0]          commit_value;

  logic                 st_commit;
  logic [DEPTH_BIT-1:0] st_commit_id;
  logic                 st_done;

  logic                 flush;
  logic [31:0]          flush_pc;

  // ROB side.
  modport slave (
    output full, empty, free_id,
    input  issue_valid, issue_type, issue_rd, issue_value, issue_ready, issue_pred, issue_alt_pc,
    input  qry1_id, qry2_id,
    output qry1_ready, qry2_ready, qry1_value, qry2_value,
    input  wb0_valid, wb0_id, wb0_value, wb1_valid, wb1_id, wb1_value,
    output dep_valid, dep_rd, dep_id,
    output commit_valid, commit_rd, commit_id, commit_value,
    output st_commit, st_commit_id,
    input  st_done,
    output flush, flush_pc
  );

  // Surrounding core side.
  modport master (
    input  full, empty, free_id,
    output issue_valid, issue_type, issue_rd, issue_value, issue_ready, issue_pred, issue_alt_pc,
    output qry1_id, qry2_id,
    input  qry1_ready, qry2_ready, qry1_value, qry2_value,
    output wb0_valid, wb0_id, wb0_value, wb1_valid, wb1_id, wb1_value,
    input  dep_valid, dep_rd, dep_id,
    input  commit_valid, commit_rd, commit_id, commit_value,
    input  st_commit, st_commit_id,
    output st_done,
    input  flush, flush_pc
  );

endinterface

// File: rtl/reorder_buffer.sv
// In-order-commit reorder buffer: circular entry array, dual writeback with query bypass,
// store release handshake and registered mispredict flush.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int unsigned DEPTH_BIT = DefDepthBit,
  parameter int unsigned TYPE_BIT  = DefTypeBit
) (
  input logic             clk_in,
  input logic             rst_in,
  input logic             rdy_in,
  reorder_buffer_if.slave rob_io
);

  localparam int unsigned Depth = 1 << DEPTH_BIT;

  typedef logic [DEPTH_BIT-1:0] id_t;
  typedef logic [DEPTH_BIT:0]   cnt_t;
  typedef logic [TYPE_BIT-1:0]  type_t;

  logic [Depth-1:0] busy_q, busy_d, done_q, done_d, pred_q, pred_d;
  type_t            type_q   [Depth];
  type_t            type_d   [Depth];
  logic [4:0]       rd_q     [Depth];
  logic [4:0]       rd_d     [Depth];
  logic [31:0]      res_q    [Depth];
  logic [31:0]      res_d    [Depth];
  logic [31:0]      alt_pc_q [Depth];
  logic [31:0]      alt_pc_d [Depth];

  id_t         head_q, head_d, tail_q, tail_d;
  cnt_t        count_q, count_d;
  rob_state_e  state_q, state_d;
  logic        flush_q, flush_d;
  logic [31:0] flush_pc_q, flush_pc_d;
  logic        st_commit_q, st_commit_d;
  id_t         st_commit_id_q, st_commit_id_d;

  logic  active, full, issue_acc, wb0_acc, wb1_acc, head_rdy, retire;
  type_t head_type;

  // Nothing but the FLUSH recovery happens while the flush is being applied.
  assign active    = (state_q != StFlush);
  // count never exceeds Depth, so its MSB alone marks a full buffer.
  assign full      = count_q[DEPTH_BIT];
  assign issue_acc = rdy_in && active && rob_io.issue_valid && !full;
  assign wb0_acc   = rdy_in && active && rob_io.wb0_valid && busy_q[rob_io.wb0_id];
  assign wb1_acc   = rdy_in && active && rob_io.wb1_valid && busy_q[rob_io.wb1_id];
  assign head_rdy  = busy_q[head_q] && done_q[head_q];
  assign head_type = type_q[head_q];

  assign rob_io.full         = full;
  assign rob_io.empty        = (count_q == '0);
  assign rob_io.free_id      = tail_q;
  assign rob_io.dep_valid    = issue_acc && (rob_io.issue_type == type_t'(TypeReg));
  assign rob_io.dep_rd       = rob_io.issue_rd;
  assign rob_io.dep_id       = tail_q;
  assign rob_io.commit_valid = rdy_in && (state_q == StRun) && head_rdy &&
                               (head_type == type_t'(TypeReg));
  assign rob_io.commit_rd    = rd_q[head_q];
  assign rob_io.commit_id    = head_q;
  assign rob_io.commit_value = res_q[head_q];
  assign rob_io.st_commit    = st_commit_q;
  assign rob_io.st_commit_id = st_commit_id_q;
  assign rob_io.flush        = flush_q;
  assign rob_io.flush_pc     = flush_pc_q;

  id_t         qry_id  [2];
  logic        qry_rdy [2];
  logic [31:0] qry_val [2];

  assign qry_id[0]         = rob_io.qry1_id;
  assign qry_id[1]         = rob_io.qry2_id;
  assign rob_io.qry1_ready = qry_rdy[0];
  assign rob_io.qry1_value = qry_val[0];
  assign rob_io.qry2_ready = qry_rdy[1];
  assign rob_io.qry2_value = qry_val[1];

  // Operand query: same-cycle writebacks and issue bypass the stored entry state.
  always_comb begin
    for (int unsigned i = 0; i < 2; i++) begin
      qry_rdy[i] = 1'b0;
      qry_val[i] = '0;
      if (wb1_acc && (rob_io.wb1_id == qry_id[i])) begin
        qry_rdy[i] = 1'b1;
        qry_val[i] = rob_io.wb1_value;
      end else if (wb0_acc && (rob_io.wb0_id == qry_id[i])) begin
        qry_rdy[i] = 1'b1;
        qry_val[i] = rob_io.wb0_value;
      end else if (issue_acc && (tail_q == qry_id[i])) begin
        qry_rdy[i] = rob_io.issue_ready;
        qry_val[i] = rob_io.issue_value;
      end else if (active) begin
        qry_rdy[i] = busy_q[qry_id[i]] && done_q[qry_id[i]];
        qry_val[i] = res_q[qry_id[i]];
      end
    end
  end

  // Next-state: issue, writeback, then the commit FSM which may retire, release or flush.
  always_comb begin
    busy_d         = busy_q;
    done_d         = done_q;
    pred_d         = pred_q;
    type_d         = type_q;
    rd_d           = rd_q;
    res_d          = res_q;
    alt_pc_d       = alt_pc_q;
    head_d         = head_q;
    tail_d         = tail_q;
    state_d        = state_q;
    flush_d        = 1'b0;
    flush_pc_d     = flush_pc_q;
    st_commit_d    = 1'b0;
    st_commit_id_d = st_commit_id_q;
    retire         = 1'b0;

    if (issue_acc) begin
      busy_d[tail_q]   = 1'b1;
      done_d[tail_q]   = rob_io.issue_ready;
      type_d[tail_q]   = rob_io.issue_type;
      rd_d[tail_q]     = rob_io.issue_rd;
      res_d[tail_q]    = rob_io.issue_value;
      pred_d[tail_q]   = rob_io.issue_pred;
      alt_pc_d[tail_q] = rob_io.issue_alt_pc;
      tail_d           = tail_q + id_t'(1);
    end
    // wb1 is applied last so it wins an id collision with wb0.
    if (wb0_acc) begin
      done_d[rob_io.wb0_id] = 1'b1;
      res_d[rob_io.wb0_id]  = rob_io.wb0_value;
    end
    if (wb1_acc) begin
      done_d[rob_io.wb1_id] = 1'b1;
      res_d[rob_io.wb1_id]  = rob_io.wb1_value;
    end

    unique case (state_q)
      StRun: begin
        if (head_rdy) begin
          if ((head_type == type_t'(TypeReg)) || (head_type == type_t'(TypeNop))) begin
            retire = 1'b1;
          end else if (head_type == type_t'(TypeBr)) begin
            if (res_q[head_q][0] != pred_q[head_q]) begin
              flush_d    = 1'b1;
              flush_pc_d = alt_pc_q[head_q];
              state_d    = StFlush;
            end else begin
              retire = 1'b1;
            end
          end else begin
            st_commit_d    = 1'b1;
            st_commit_id_d = head_q;
            state_d        = StStWait;
          end
        end
      end
      StStWait: begin
        if (rob_io.st_done) begin
          retire  = 1'b1;
          state_d = StRun;
        end
      end
      StFlush: begin
        busy_d  = '0;
        done_d  = '0;
        head_d  = '0;
        tail_d  = '0;
        state_d = StRun;
      end
      default: state_d = StRun;
    endcase

    if (retire) begin
      busy_d[head_q] = 1'b0;
      done_d[head_q] = 1'b0;
      head_d         = head_q + id_t'(1);
    end

    count_d = count_q + cnt_t'(issue_acc) - cnt_t'(retire);
    if (state_q == StFlush) begin
      count_d = '0;
    end
  end

  // State registers: synchronous reset, frozen while rdy_in is low.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy_q         <= '0;
      done_q         <= '0;
      pred_q         <= '0;
      for (int unsigned i = 0; i < Depth; i++) begin
        type_q[i]   <= '0;
        rd_q[i]     <= '0;
        res_q[i]    <= '0;
        alt_pc_q[i] <= '0;
      end
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      state_q        <= StRun;
      flush_q        <= 1'b0;
      flush_pc_q     <= '0;
      st_commit_q    <= 1'b0;
      st_commit_id_q <= '0;
    end else if (rdy_in) begin
      busy_q         <= busy_d;
      done_q         <= done_d;
      pred_q         <= pred_d;
      type_q         <= type_d;
      rd_q           <= rd_d;
      res_q          <= res_d;
      alt_pc_q       <= alt_pc_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      state_q        <= state_d;
      flush_q        <= flush_d;
      flush_pc_q     <= flush_pc_d;
      st_commit_q    <= st_commit_d;
      st_commit_id_q <= st_commit_id_d;
    end
  end

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

Parametrised in-order-commit reorder buffer for the Tomasulo core, sitting between Decoder (issue), RS/LSB (writeback), RF (rename/commit) and LSB (store release). Generalises the earlier fixed 32-entry ROB in several ways:
- configurable depth;
- two writeback ports with same-cycle query bypass;
- explicit store-commit handshake with LSB;
- a registered branch-mispredict flush carrying the redirect PC.

## Interface
Parameters:
- `DEPTH_BIT`, 4: log2 of entry count; DEPTH = 2^DEPTH_BIT.
- `TYPE_BIT`, 2: width of entry type field.

Ports (`rdy_in` low freezes all state):
- `clk_in` in 1: system clock; one clock domain.
- `rst_in` in 1: synchronous, active-high reset.
- `rdy_in` in 1: pause when low.
- `full` out 1: count == DEPTH.
- `empty` out 1: count == 0.
- `free_id` out DEPTH_BIT: tail index, the id the next issue will receive.
- `issue_valid` in 1: Decoder pushes an entry.
- `issue_type` in TYPE_BIT: REG / ST / BR / NOP.
- `issue_rd` in 5: destination register (REG only).
- `issue_value` in 32: result if already known (lui, auipc, jal link).
- `issue_ready` in 1: entry finished at issue.
- `issue_pred` in 1: predicted taken (BR only).
- `issue_alt_pc` in 32: PC of the non-predicted path (BR only).
- `qry1_id`, `qry2_id` in DEPTH_BIT: operand dependency ids.
- `qry1_ready`, `qry2_ready` out 1: the queried entry's result is available.
- `qry1_value`, `qry2_value` out 32: the queried entry's result.
- `wb0_valid`, `wb0_id`, `wb0_value` in 1/DEPTH_BIT/32: RS/ALU result.
- `wb1_valid`, `wb1_id`, `wb1_value` in 1/DEPTH_BIT/32: LSB result.
- `dep_valid`, `dep_rd`, `dep_id` out 1/5/DEPTH_BIT: RF rename, combinational from issue.
- `commit_valid`, `commit_rd`, `commit_id`, `commit_value` out 1/5/DEPTH_BIT/32: RF write, combinational from head.
- `st_commit` out 1 (reg): one-cycle pulse releasing the head store in LSB.
- `st_commit_id` out DEPTH_BIT (reg): id of the released store.
- `st_done` in 1: LSB reports the released store has been performed.
- `flush` out 1 (reg): one-cycle mispredict flush to all units.
- `flush_pc` out 32 (reg): redirect address for the fetch unit.

## Operation
- Circular buffer with `head` and `tail` (DEPTH_BIT bits, natural wrap) and `count` (DEPTH_BIT+1 bits).
- Per-entry fields: `busy`, `done`, `type`, `rd`, `res[31:0]`, `pred`, `alt_pc`.
- Issue is accepted when `issue_valid && !full`; otherwise it is ignored. Accepting writes `tail` and increments it. `dep_valid = issue_valid && !full && type==REG`.
- Writeback sets `done` and `res` of the addressed entry. If `wb0_id == wb1_id` in the same cycle, wb1 wins. Writeback to a non-busy entry is ignored.
- Query is combinational, priority order: wb1 match, wb0 match, issue to the same id, stored `done`/`res`.
- FSM states, all transitions taken only when `rdy_in` is high:
  - RUN: head is busy and done.
    - REG: `commit_valid` is high this cycle; retire.
    - NOP: retire.
    - BR: if `res[0] != pred`, register `flush`=1 and `flush_pc`=alt_pc, go to FLUSH. Otherwise retire.
    - ST: register `st_commit`=1 with `st_commit_id`=head, go to ST_WAIT.
  - ST_WAIT: `st_commit` is 0. On `st_done`, retire the store and return to RUN. `st_done` arriving in the same cycle as the `st_commit` pulse is accepted.
  - FLUSH: on the next cycle clear all `busy`/`done`, set head = tail = count = 0, drop `st_commit`, return to RUN. Issue, writeback and query are ignored while in FLUSH.
- At most one retire per cycle. Simultaneous issue and retire leave `count` unchanged.

## Timing
- Reset (synchronous, `rst_in` high at a rising edge):
  - all entries cleared; head = tail = count = 0;
  - FSM to RUN;
  - `flush`=0, `flush_pc`=0, `st_commit`=0, `st_commit_id`=0;
  - combinational outputs therefore read `full`=0, `empty`=1, `free_id`=0, `commit_valid`=0, `dep_valid`=0, `qry*_ready`=0 (for idle inputs).
- Reset mid-ST_WAIT or mid-FLUSH also returns to RUN with no pulse emitted.
- Timing of each path:
  - Issue to visible in `qry*` from stored state: next cycle. Bypass covers the same cycle.
  - Writeback to head retire: next cycle at earliest (`commit_valid` asserts the cycle after writeback).
  - Mispredicted BR done at head: `flush` high exactly one cycle later; buffer empty the cycle after that.
  - Store at head done: `st_commit` high one cycle later, for exactly one cycle.
- `full` does not credit a same-cycle retire; this is conservative.
- `rdy_in` low:
  - no state changes;
  - `commit_valid` and `dep_valid` forced to 0;
  - registered pulses hold their value and complete on the next ready cycle.

## Structure
- Shared `Config.v` defines: ROB_TYPE codes (REG=0, ST=1, BR=2, NOP=3), the ROB_TYPE_BIT default, the FSM state encodings, and the default DEPTH_BIT.
- Single module; no sub-module needed. The entry array is plain register arrays indexed by head/tail.

## Test plan
- Reset, then issue REG rd=5 with value 0x1234 ready -> `dep_valid`=1, `dep_id`=0. Next cycle `commit_valid`=1, `commit_rd`=5, `commit_value`=0x1234, `empty`=1 after retire.
- DEPTH_BIT=2: issue 4 REG not ready -> `full`=1 and a 5th issue is ignored. Writeback ids 0..3 -> retire one per cycle. Tail wraps to 0.
- Same-cycle `wb0_id`=2 value 7 and `qry1_id`=2 -> `qry1_ready`=1, `qry1_value`=7. With `wb0_id`=`wb1_id`=2 (values 7 and 9) -> value 9.
- BR pred=1, wb `res`=0, alt_pc=0x100 -> `flush`=1 with `flush_pc`=0x100 for one cycle. Younger entries are discarded and `free_id`=0 afterwards.
- ST at head done -> single `st_commit` pulse with id; head holds until `st_done` 3 cycles later, then retires.
- Assert `rst_in` during ST_WAIT -> no `st_commit`, `empty`=1, FSM in RUN.
